// File: rtl/buffer_pkgs.sv
// rtl/buffer_pkgs.sv - execute-stage result and writeback packet types shared by the writeback path
package buffer_pkgs;

  typedef struct packed {
    logic        completed;
    logic [6:0]  rd_addr;
    logic [31:0] rd_val;
    logic [3:0]  ROB_tag;
  } alu_out_t;

  typedef struct packed {
    logic        completed;
    logic [6:0]  rd_addr;
    logic [31:0] rd_val;
    logic [3:0]  ROB_tag;
  } lsu_out_t;

  typedef struct packed {
    logic        completed;
    logic [6:0]  rd_addr;
    logic [31:0] rd_val;
    logic [3:0]  ROB_tag;
    logic        mispredict;
    logic        branch_taken;
    logic [31:0] dest_addr;
  } branch_out_t;

  typedef struct packed {
    logic [6:0]  rd_addr;
    logic [31:0] rd_val;
    logic        completed;
    logic        mispredict;
    logic        branch_taken;
    logic [31:0] dest_addr;
    logic [3:0]  ROB_tag;
    logic [1:0]  src_fu;
  } wb_packet_t;

  localparam logic [1:0] WB_SRC_ALU = 2'd0;
  localparam logic [1:0] WB_SRC_LSU = 2'd1;
  localparam logic [1:0] WB_SRC_BR  = 2'd2;

  typedef enum logic [1:0] {GNT_ALU, GNT_LSU, GNT_BR} wb_gnt_e;

  function automatic wb_gnt_e gnt_after(input wb_gnt_e g);
    case (g)
      GNT_ALU: gnt_after = GNT_LSU;
      GNT_LSU: gnt_after = GNT_BR;
      default: gnt_after = GNT_ALU;
    endcase
  endfunction

  // First non-empty unit in ALU->LSU->BR order, starting the search at start.
  function automatic wb_gnt_e rr_pick(input wb_gnt_e start, input logic [2:0] ne);
    wb_gnt_e cand;
    logic    found;
    rr_pick = start;
    cand    = start;
    found   = 1'b0;
    for (int i = 0; i < 3; i++) begin
      if (!found && ne[cand]) begin
        rr_pick = cand;
        found   = 1'b1;
      end
      cand = gnt_after(cand);
    end
  endfunction

endpackage

// File: rtl/wb_arbiter_fifo.sv
// rtl/wb_arbiter_fifo.sv - per-unit writeback packet FIFO (module wb_fu_fifo)
module wb_fu_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 2,
  parameter int CNT_W = $clog2(DEPTH + 1),
  localparam int PTR_W = $clog2(DEPTH)
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic             flush_i,
  input  logic             push_i,
  input  logic [WIDTH-1:0] din_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] dout_o,
  output logic             ready_o,
  output logic             not_empty_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0] count_q, count_d;
  logic             do_push, do_pop;

  // A full FIFO refuses a push even when it is popped the same cycle.
  assign ready_o     = (count_q != CNT_W'(DEPTH));
  assign not_empty_o = (count_q != '0);
  assign do_push     = push_i && ready_o;
  assign do_pop      = pop_i && not_empty_o;
  assign dout_o      = mem_q[rd_ptr_q];

  always_comb begin
    count_d = count_q;
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (reset_i || flush_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      count_q <= count_d;
      if (do_push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push && !flush_i && !reset_i) mem_q[wr_ptr_q] <= din_i;
  end

endmodule

// File: rtl/wb_arbiter.sv
// rtl/wb_arbiter.sv - buffers ALU/LSU/branch completions and serialises them onto the writeback port
// Optional: WB_BRANCH_PRIORITY_EN gives an unlocked non-empty branch FIFO the grant.
module wb_arbiter
  import buffer_pkgs::*;
#(
  parameter int FIFO_DEPTH = 2,
  localparam int CNT_W = $clog2(FIFO_DEPTH + 1)
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        flush,
  input  alu_out_t    alu_in,
  output logic        alu_ready,
  input  lsu_out_t    lsu_in,
  output logic        lsu_ready,
  input  branch_out_t br_in,
  output logic        br_ready,
  output wb_packet_t  wb_out,
  output logic        wb_valid,
  input  logic        wb_ready
);

  wb_packet_t alu_pkt, lsu_pkt, br_pkt;
  wb_packet_t head [3];
  logic [2:0] ne, rdy, pop;
  logic       handshake;
  logic       lock_q, lock_d;
  wb_gnt_e    gnt, gnt_q, gnt_d, rr_q, rr_d;

  always_comb begin
    alu_pkt              = '0;
    alu_pkt.rd_addr      = alu_in.rd_addr;
    alu_pkt.rd_val       = alu_in.rd_val;
    alu_pkt.ROB_tag      = alu_in.ROB_tag;
    alu_pkt.completed    = 1'b1;
    alu_pkt.src_fu       = WB_SRC_ALU;
    lsu_pkt              = '0;
    lsu_pkt.rd_addr      = lsu_in.rd_addr;
    lsu_pkt.rd_val       = lsu_in.rd_val;
    lsu_pkt.ROB_tag      = lsu_in.ROB_tag;
    lsu_pkt.completed    = 1'b1;
    lsu_pkt.src_fu       = WB_SRC_LSU;
    br_pkt               = '0;
    br_pkt.rd_addr       = br_in.rd_addr;
    br_pkt.rd_val        = br_in.rd_val;
    br_pkt.ROB_tag       = br_in.ROB_tag;
    br_pkt.completed     = 1'b1;
    br_pkt.mispredict    = br_in.mispredict;
    br_pkt.branch_taken  = br_in.branch_taken;
    br_pkt.dest_addr     = br_in.dest_addr;
    br_pkt.src_fu        = WB_SRC_BR;
  end

  wb_fu_fifo #(.WIDTH($bits(wb_packet_t)), .DEPTH(FIFO_DEPTH), .CNT_W(CNT_W)) u_alu_fifo (
    .clk_i(clk), .reset_i(reset), .flush_i(flush), .push_i(alu_in.completed), .din_i(alu_pkt),
    .pop_i(pop[0]), .dout_o(head[0]), .ready_o(rdy[0]), .not_empty_o(ne[0])
  );
  wb_fu_fifo #(.WIDTH($bits(wb_packet_t)), .DEPTH(FIFO_DEPTH), .CNT_W(CNT_W)) u_lsu_fifo (
    .clk_i(clk), .reset_i(reset), .flush_i(flush), .push_i(lsu_in.completed), .din_i(lsu_pkt),
    .pop_i(pop[1]), .dout_o(head[1]), .ready_o(rdy[1]), .not_empty_o(ne[1])
  );
  wb_fu_fifo #(.WIDTH($bits(wb_packet_t)), .DEPTH(FIFO_DEPTH), .CNT_W(CNT_W)) u_br_fifo (
    .clk_i(clk), .reset_i(reset), .flush_i(flush), .push_i(br_in.completed), .din_i(br_pkt),
    .pop_i(pop[2]), .dout_o(head[2]), .ready_o(rdy[2]), .not_empty_o(ne[2])
  );

  assign alu_ready = rdy[0];
  assign lsu_ready = rdy[1];
  assign br_ready  = rdy[2];
  assign wb_valid  = |ne;
  assign handshake = wb_valid && wb_ready;

  // A stalled output keeps its grant so wb_out stays bit-stable.
  always_comb begin
`ifdef WB_BRANCH_PRIORITY_EN
    if (lock_q)     gnt = gnt_q;
    else if (ne[2]) gnt = GNT_BR;
    else            gnt = rr_pick(rr_q, ne);
`else
    gnt = lock_q ? gnt_q : rr_pick(rr_q, ne);
`endif
  end

  always_comb begin
    wb_out = wb_valid ? head[gnt] : '0;
    pop    = handshake ? (3'b001 << gnt) : 3'b000;
    lock_d = wb_valid && !wb_ready;
    gnt_d  = gnt;
    rr_d   = rr_q;
`ifdef WB_BRANCH_PRIORITY_EN
    if (handshake && gnt != GNT_BR) rr_d = gnt_after(gnt);
`else
    if (handshake) rr_d = gnt_after(gnt);
`endif
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rr_q   <= GNT_ALU;
      gnt_q  <= GNT_ALU;
      lock_q <= 1'b0;
    end else if (flush) begin
      lock_q <= 1'b0;
    end else begin
      rr_q   <= rr_d;
      gnt_q  <= gnt_d;
      lock_q <= lock_d;
    end
  end

endmodule

// File: tb/tb_wb_arbiter.sv
// tb/tb_wb_arbiter.sv - scoreboard bench for wb_arbiter with directed vectors
module tb_wb_arbiter;
  import buffer_pkgs::*;

  logic        clk = 1'b0;
  logic        reset, flush, wb_ready;
  logic        alu_ready, lsu_ready, br_ready, wb_valid;
  alu_out_t    alu_in;
  lsu_out_t    lsu_in;
  branch_out_t br_in;
  wb_packet_t  wb_out;

  int n_checks = 0;
  int n_fail   = 0;
  wb_packet_t exp_q[$];

  always #5 clk = ~clk;

  wb_arbiter #(.FIFO_DEPTH(2)) dut (
    .clk(clk), .reset(reset), .flush(flush),
    .alu_in(alu_in), .alu_ready(alu_ready),
    .lsu_in(lsu_in), .lsu_ready(lsu_ready),
    .br_in(br_in), .br_ready(br_ready),
    .wb_out(wb_out), .wb_valid(wb_valid), .wb_ready(wb_ready)
  );

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic alu_out_t mk_alu(input logic [6:0] rd, input logic [31:0] v, input logic [3:0] t);
    mk_alu = '{completed: 1'b1, rd_addr: rd, rd_val: v, ROB_tag: t};
  endfunction

  function automatic lsu_out_t mk_lsu(input logic [6:0] rd, input logic [31:0] v, input logic [3:0] t);
    mk_lsu = '{completed: 1'b1, rd_addr: rd, rd_val: v, ROB_tag: t};
  endfunction

  function automatic branch_out_t mk_br(input logic [6:0] rd, input logic [31:0] v, input logic [3:0] t,
                                        input logic mp, input logic tk, input logic [31:0] dst);
    mk_br = '{completed: 1'b1, rd_addr: rd, rd_val: v, ROB_tag: t,
              mispredict: mp, branch_taken: tk, dest_addr: dst};
  endfunction

  function automatic wb_packet_t ex(input logic [6:0] rd, input logic [31:0] v, input logic [3:0] t,
                                    input logic [1:0] src, input logic mp, input logic tk,
                                    input logic [31:0] dst);
    ex = '{rd_addr: rd, rd_val: v, completed: 1'b1, mispredict: mp, branch_taken: tk,
           dest_addr: dst, ROB_tag: t, src_fu: src};
  endfunction

  // Monitor: whenever a packet is presented it must equal the scoreboard head.
  always @(negedge clk) begin
    if (!reset) begin
      if (wb_valid) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_output: got %0h expected no packet", wb_out);
        end else begin
          check("wb_out", wb_out, exp_q[0]);
          if (wb_ready) void'(exp_q.pop_front());
        end
      end else begin
        check("wb_out_idle", wb_out, '0);
      end
    end
  end

  task automatic push_lsu(input lsu_out_t p);
    bit ok = 1'b0;
    lsu_in = p;
    for (int i = 0; i < 20 && !ok; i++) begin
      @(negedge clk); ok = lsu_ready;
      @(posedge clk); #1;
    end
    lsu_in = '0;
    if (!ok) begin n_checks++; n_fail++; $display("FAIL push_lsu_timeout: got ready=0 expected ready=1"); end
  endtask

  task automatic push_br(input branch_out_t p);
    bit ok = 1'b0;
    br_in = p;
    for (int i = 0; i < 20 && !ok; i++) begin
      @(negedge clk); ok = br_ready;
      @(posedge clk); #1;
    end
    br_in = '0;
    if (!ok) begin n_checks++; n_fail++; $display("FAIL push_br_timeout: got ready=0 expected ready=1"); end
  endtask

  task automatic drained(input string name);
    repeat (5) @(posedge clk);
    @(negedge clk);
    check({name, "_queue_empty"}, exp_q.size(), 0);
    check({name, "_valid_low"}, wb_valid, 1'b0);
    @(posedge clk); #1;
  endtask

  initial begin
    reset = 1'b1; flush = 1'b0; wb_ready = 1'b0;
    alu_in = '0; lsu_in = '0; br_in = '0;
    repeat (2) @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    check("rst_valid", wb_valid, 1'b0);
    check("rst_out", wb_out, '0);
    check("rst_readies", {alu_ready, lsu_ready, br_ready}, 3'b111);

    // Single ALU packet: visible one cycle after the push edge, gone after the pop.
    @(posedge clk); #1;
    wb_ready = 1'b1;
    exp_q.push_back(ex(7'd5, 32'hDEAD_BEEF, 4'd3, 2'd0, 1'b0, 1'b0, 32'h0));
    alu_in = mk_alu(7'd5, 32'hDEAD_BEEF, 4'd3);
    @(negedge clk);
    check("t1_no_bypass", wb_valid, 1'b0);
    @(posedge clk); #1;
    alu_in = '0;
    @(negedge clk);
    check("t1_latency", wb_valid, 1'b1);
    @(posedge clk);
    @(negedge clk);
    check("t1_valid_drop", wb_valid, 1'b0);

    // Simultaneous arrival from all three units after reset (rr at ALU).
    @(posedge clk); #1; reset = 1'b1;
    @(posedge clk); #1; reset = 1'b0;
`ifdef WB_BRANCH_PRIORITY_EN
    exp_q.push_back(ex(7'd12, 32'h4444, 4'd4, 2'd2, 1'b0, 1'b0, 32'h0));
    exp_q.push_back(ex(7'd10, 32'h1111, 4'd1, 2'd0, 1'b0, 1'b0, 32'h0));
    exp_q.push_back(ex(7'd11, 32'h2222, 4'd2, 2'd1, 1'b0, 1'b0, 32'h0));
`else
    exp_q.push_back(ex(7'd10, 32'h1111, 4'd1, 2'd0, 1'b0, 1'b0, 32'h0));
    exp_q.push_back(ex(7'd11, 32'h2222, 4'd2, 2'd1, 1'b0, 1'b0, 32'h0));
    exp_q.push_back(ex(7'd12, 32'h4444, 4'd4, 2'd2, 1'b0, 1'b0, 32'h0));
`endif
    alu_in = mk_alu(7'd10, 32'h1111, 4'd1);
    lsu_in = mk_lsu(7'd11, 32'h2222, 4'd2);
    br_in  = mk_br(7'd12, 32'h4444, 4'd4, 1'b0, 1'b0, 32'h0);
    @(posedge clk); #1;
    alu_in = '0; lsu_in = '0; br_in = '0;
    drained("t2");

    // Stalled LSU grant must stay put while a BR packet arrives behind it.
    wb_ready = 1'b0;
    exp_q.push_back(ex(7'd20, 32'h5555_0000, 4'd5, 2'd1, 1'b0, 1'b0, 32'h0));
    exp_q.push_back(ex(7'd21, 32'h6666_0000, 4'd6, 2'd2, 1'b1, 1'b0, 32'h80));
    push_lsu(mk_lsu(7'd20, 32'h5555_0000, 4'd5));
    repeat (3) @(posedge clk); #1;
    push_br(mk_br(7'd21, 32'h6666_0000, 4'd6, 1'b1, 1'b0, 32'h80));
    repeat (2) @(posedge clk); #1;
    wb_ready = 1'b1;
    drained("t3");

    // Depth-2 ALU FIFO fills; third packet is held by the unit and keeps its order.
    wb_ready = 1'b0;
    exp_q.push_back(ex(7'd1, 32'hA, 4'd7, 2'd0, 1'b0, 1'b0, 32'h0));
    exp_q.push_back(ex(7'd2, 32'hB, 4'd8, 2'd0, 1'b0, 1'b0, 32'h0));
    exp_q.push_back(ex(7'd3, 32'hC, 4'd9, 2'd0, 1'b0, 1'b0, 32'h0));
    alu_in = mk_alu(7'd1, 32'hA, 4'd7);
    @(posedge clk); #1;
    alu_in = mk_alu(7'd2, 32'hB, 4'd8);
    @(negedge clk);
    check("t4_ready_after1", alu_ready, 1'b1);
    @(posedge clk); #1;
    alu_in = mk_alu(7'd3, 32'hC, 4'd9);
    @(negedge clk);
    check("t4_full", alu_ready, 1'b0);
    @(posedge clk); #1;
    wb_ready = 1'b1;
    @(negedge clk);
    check("t4_full_during_pop", alu_ready, 1'b0);
    @(posedge clk); #1;
    @(negedge clk);
    check("t4_refused_on_pop", alu_ready, 1'b1);
    @(posedge clk); #1;
    alu_in = '0;
    drained("t4");

    // Flush with two LSU packets buffered and a coincident BR push.
    wb_ready = 1'b0;
    exp_q.push_back(ex(7'd30, 32'h3030, 4'd10, 2'd1, 1'b0, 1'b0, 32'h0));
    exp_q.push_back(ex(7'd31, 32'h3131, 4'd11, 2'd1, 1'b0, 1'b0, 32'h0));
    push_lsu(mk_lsu(7'd30, 32'h3030, 4'd10));
    push_lsu(mk_lsu(7'd31, 32'h3131, 4'd11));
    flush = 1'b1;
    br_in = mk_br(7'd32, 32'h3232, 4'd12, 1'b1, 1'b1, 32'h900);
    @(posedge clk); #1;
    flush = 1'b0;
    br_in = '0;
    exp_q.delete();
    @(negedge clk);
    check("t5_valid_low", wb_valid, 1'b0);
    check("t5_readies", {alu_ready, lsu_ready, br_ready}, 3'b111);
    @(posedge clk); #1;
    wb_ready = 1'b1;
    drained("t5");

    // Branch fields pass through with src_fu = 2.
    exp_q.push_back(ex(7'd0, 32'h1234, 4'd13, 2'd2, 1'b1, 1'b1, 32'h0000_0400));
    push_br(mk_br(7'd0, 32'h1234, 4'd13, 1'b1, 1'b1, 32'h0000_0400));
    drained("t6");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/wb_arbiter.md
Name: wb_arbiter

Overview:
Collects completion packets from the ALU, LSU and branch units and converts each to the unified wb_packet_t. Serialises them onto the single CDB/writeback port feeding the PRF and ROB.
Each FU gets a small FIFO so FUs never stall on a same-cycle collision. Arbitration is round-robin with a held grant and ready/valid handshake on the output. Sits between the execute stage and the ROB/PRF writeback.

Parameters:
FIFO_DEPTH, 2, entries per FU FIFO (power of two, >=2)
CNT_W, $clog2(FIFO_DEPTH+1), occupancy counter width (derived, not overridden)

Ports:
clk  in  1  core clock
reset  in  1  synchronous active-high reset
flush  in  1  mispredict squash; clears all buffered packets
alu_in  in  alu_out_t  ALU result; alu_in.completed = valid
alu_ready  out  1  ALU FIFO not full
lsu_in  in  lsu_out_t  LSU result; lsu_in.completed = valid
lsu_ready  out  1  LSU FIFO not full
br_in  in  branch_out_t  branch result; br_in.completed = valid
br_ready  out  1  branch FIFO not full
wb_out  out  wb_packet_t  packet to CDB/ROB
wb_valid  out  1  wb_out holds a packet
wb_ready  in  1  consumer accepts wb_out this cycle

Behaviour:
- Reset (synchronous, active-high): all FIFOs empty, counts 0, rr pointer = ALU, grant lock cleared.
  - Outputs after reset: wb_valid=0, wb_out='0, all *_ready=1.
- Push:
  - FU FIFO x enqueues on the rising edge when x_in.completed && x_ready.
  - x_ready = (count_x != FIFO_DEPTH), combinational from registered count only, never from the pop.
  - A full FIFO refuses a push even if a pop happens the same cycle.
  - A completed FU packet presented while x_ready=0 is the FU's responsibility to hold.
- Pop: the granted FIFO dequeues on the edge when wb_valid && wb_ready. Simultaneous push and pop on the same FIFO keeps count unchanged.
- Latency: minimum 1 cycle, from FU completion edge to wb_valid. No bypass path.
- wb_valid = any FIFO non-empty.
- wb_out is combinational from the granted FIFO head; it is '0 when wb_valid=0.
- Packing:
  - ALU: rd_addr, rd_val, ROB_tag copied; completed=1; mispredict=0; branch_taken=0; dest_addr=0; src_fu=0.
  - LSU: same as ALU but src_fu=1. rd_addr=0 for stores is passed through unchanged.
  - BR: all matching fields copied, including mispredict, branch_taken, dest_addr; src_fu=2.
- Arbitration:
  - Round-robin order ALU->LSU->BR, starting search at the rr pointer.
  - On handshake, rr pointer moves to the unit after the granted one.
- Grant lock: while wb_valid && !wb_ready, the grant is frozen and wb_out must stay bit-stable, even if a higher-priority FIFO becomes non-empty.
- Flush:
  - On the edge with flush=1, all counts and pointers clear and the lock clears. Same-cycle pushes are dropped (flush wins).
  - A same-cycle pop is irrelevant.
  - rr pointer is kept.
  - Next cycle: wb_valid=0.
- FIFO pointers: read/write pointers of width $clog2(FIFO_DEPTH) wrap naturally. Count is tracked separately to distinguish full from empty.
- Reset mid-operation behaves as flush plus rr pointer reset to ALU.

Optional Feature:
WB_BRANCH_PRIORITY_EN
- Defined: a non-empty branch FIFO wins whenever no grant is locked, so mispredict redirects reach the ROB earliest. ALU/LSU remain round-robin between themselves, and the rr pointer is not updated by branch grants.
- Undefined: pure three-way round-robin as above.

Decomposition:
- Shared package buffer_pkgs:
  - Already holds alu_out_t, lsu_out_t, branch_out_t, wb_packet_t.
  - Add localparams WB_SRC_ALU=2'd0, WB_SRC_LSU=2'd1, WB_SRC_BR=2'd2.
  - Add typedef enum logic [1:0] {GNT_ALU, GNT_LSU, GNT_BR} wb_gnt_e.
- One sub-module, wb_fu_fifo: parameterised over width and depth, carrying a packed wb_packet_t. It is instantiated three times, and packing happens before the push.

Test Plan:
- Reset, then an ALU packet with rd_addr=7'd5, rd_val=32'hDEAD_BEEF, ROB_tag=4'd3 and wb_ready=1 -> next cycle wb_valid=1, wb_out={5, DEADBEEF, completed=1, mispredict=0, tag 3, src_fu=0}; the cycle after, wb_valid=0.
- Same-cycle ALU tag 1, LSU tag 2, BR tag 4, wb_ready=1 -> tags emitted on consecutive cycles in order 1, 2, 4 (with WB_BRANCH_PRIORITY_EN: 4, 1, 2).
- wb_ready=0 for 3 cycles with the LSU head granted, then a BR packet arrives -> wb_out stays the LSU packet bit-identical until wb_ready=1.
- FIFO_DEPTH=2, push 3 ALU packets back-to-back with wb_ready=0 -> alu_ready=0 after the 2nd push; the 3rd is held by the FU; after one pop, the 3rd enters and its order is preserved.
- Two LSU packets buffered, flush=1 coincident with a new BR push -> next cycle wb_valid=0, all readies=1, and the BR packet is never emitted.
- BR packet with mispredict=1, branch_taken=1, dest_addr=32'h0000_0400 -> wb_out carries those values with src_fu=2'd2.
